// File: rtl/imem_boot_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
// Optional checksum stage is enabled by IMEM_BOOT_LOADER_CHECKSUM_EN.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        CHK    = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } state_e;

    localparam int WORD_BYTES = 4;

    function automatic logic len_too_big(input logic [15:0] n, input int depth);
        return 32'(n) > depth;
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words and emits a
// one-cycle word strobe after every fourth byte.
module boot_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic        last_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [23:0] pack_q, pack_d;
    logic        wv_q,   wv_d;
    logic [31:0] word_q, word_d;

    assign last_o       = (cnt_q == 2'(WORD_BYTES - 1));
    assign word_valid_o = wv_q;
    assign word_o       = word_q;

    always_comb begin
        cnt_d  = cnt_q;
        pack_d = pack_q;
        wv_d   = 1'b0;
        word_d = word_q;
        if (clr_i) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (valid_i) begin
            // Newest byte enters at the top so the first byte ends up as the LSB.
            pack_d = {byte_i, pack_q[23:8]};
            cnt_d  = cnt_q + 2'd1;
            if (last_o) begin
                wv_d   = 1'b1;
                word_d = {byte_i, pack_q};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            pack_q <= '0;
            wv_q   <= 1'b0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
            wv_q   <= wv_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed byte image into instruction memory and holds
// the CPU in reset until loaded. Checksum stage: IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 9
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    input  logic              reload_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_o,
    output logic              done_o,
    output logic              err_o
);
    import imem_boot_loader_pkg::*;

    localparam int WCNT_W = $clog2(DEPTH + 1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    localparam state_e LOAD_END = CHK;
`else
    localparam state_e LOAD_END = RUN;
`endif

    state_e              state_q,   state_d;
    logic                ready_q,   ready_d;
    logic [7:0]          len_lo_q,  len_lo_d;
    logic [WCNT_W-1:0]   n_q,       n_d;
    logic [WCNT_W-1:0]   wcnt_q,    wcnt_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q,    done_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [7:0]          xor_q,     xor_d;
`endif

    logic        accept;
    logic        data_acc;
    logic        pk_clr;
    logic        pk_last;
    logic        pk_wv;
    logic [31:0] pk_word;
    logic [15:0] n_full;
    logic        in_run;

    assign accept   = byte_valid_i & ready_q;
    assign data_acc = accept & (state_q == DATA);
    assign n_full   = {byte_data_i, len_lo_q};
    assign in_run   = (state_q == RUN) & ~reload_i;

    boot_word_packer u_packer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (pk_clr),
        .byte_i       (byte_data_i),
        .valid_i      (data_acc),
        .last_o       (pk_last),
        .word_valid_o (pk_wv),
        .word_o       (pk_word)
    );

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        wcnt_d   = wcnt_q;
        addr_d   = addr_q;
        pk_clr   = 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        xor_d    = accept ? (xor_q ^ byte_data_i) : xor_q;
`endif
        unique case (state_q)
            LEN_LO: if (accept) begin
                len_lo_d = byte_data_i;
                state_d  = LEN_HI;
            end
            LEN_HI: if (accept) begin
                n_d = WCNT_W'(n_full);
                if (len_too_big(n_full, DEPTH))
                    state_d = ERR;
                else if (n_full == 16'd0)
                    state_d = LOAD_END;
                else
                    state_d = DATA;
            end
            DATA: if (data_acc && pk_last) begin
                addr_d = ADDR_W'(32'(wcnt_q) * WORD_BYTES);
                wcnt_d = wcnt_q + WCNT_W'(1);
                if (wcnt_q == n_q - WCNT_W'(1))
                    state_d = LOAD_END;
            end
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            CHK: if (accept) begin
                state_d = ((xor_q ^ byte_data_i) == 8'h00) ? RUN : ERR;
            end
`endif
            RUN, ERR: if (reload_i) begin
                state_d  = LEN_LO;
                len_lo_d = '0;
                n_d      = '0;
                wcnt_d   = '0;
                pk_clr   = 1'b1;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                xor_d    = '0;
`endif
            end
            default: state_d = ERR;
        endcase
        ready_d   = state_d inside {LEN_LO, LEN_HI, DATA, CHK};
        // Release lags RUN entry by a cycle so the final write lands first.
        cpu_rst_d = ~in_run;
        done_d    = in_run;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= LEN_LO;
            ready_q   <= 1'b0;
            len_lo_q  <= '0;
            n_q       <= '0;
            wcnt_q    <= '0;
            addr_q    <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            xor_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            len_lo_q  <= len_lo_d;
            n_q       <= n_d;
            wcnt_q    <= wcnt_d;
            addr_q    <= addr_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            xor_q     <= xor_d;
`endif
        end
    end

    assign byte_ready_o = ready_q;
    assign imem_we_o    = pk_wv;
    assign imem_addr_o  = addr_q;
    assign imem_data_o  = pk_word;
    assign cpu_rst_o    = cpu_rst_q;
    assign done_o       = done_q;
    assign err_o        = (state_q == ERR);

endmodule
